mc_lsu: RTL

//  Parametrised load/store unit for the multi-cycle core's unified memory port.

---
 rtl/mc_lsu_if.sv | 49 ++++
 rtl/mc_lsu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mc_lsu_if.sv
// mc_lsu_if: bundles the three bus groups of the load/store unit.
//   req_*  core -> LSU request, with its req_ready handshake
//   resp_* LSU -> core completion pulse, read data and fault code
//   mem_*  LSU -> unified memory port (mem_req/mem_rdy handshake)
// Modports:
//   master - the surroundings: core control FSM and memory
//   slave  - the LSU itself
interface mc_lsu_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  localparam int NB = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic [1:0]      resp_fault;

  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [NB-1:0]   mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rdy;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_rdy, mem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_rdy, mem_rdata
  );
endinterface

// File: rtl/mc_lsu.sv
// mc_lsu: load/store unit for the multi-cycle core's unified memory port.
// Accepts one request at a time, issues a single bus cycle with lane-aligned
// data and byte strobes, extends read data, and reports misaligned,
// illegal-size and bus-timeout faults. Any fault sets a sticky halt flag.
// Ports:
//   clk, sys_rst_n  clock and asynchronous active-low reset
//   bus             mc_lsu_if.slave (req_*, resp_*, mem_* groups)
//   halt            sticky fault flag, cleared only by reset
//   busy            high whenever the unit is not idle
module mc_lsu #(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     sys_rst_n,
  mc_lsu_if.slave  bus,
  output logic     halt,
  output logic     busy
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam bit HAS_DW = (XLEN == 64);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] F_OK   = 2'b00;
  localparam logic [1:0] F_MIS  = 2'b01;
  localparam logic [1:0] F_TO   = 2'b10;
  localparam logic [1:0] F_SIZE = 2'b11;

  logic [1:0]      state;
  logic [15:0]     cnt;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [OB-1:0]   off_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [NB-1:0]   wstrb_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [1:0]      fault_q;
  logic            halt_q;

  // Request decode: fault classification, strobes and lane replication.
  logic [1:0]      req_fault;
  logic [NB-1:0]   req_strb;
  logic [XLEN-1:0] req_wrep;
  logic [OB-1:0]   req_off;

  assign req_off = bus.req_addr[OB-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    req_fault = F_OK;
    req_strb  = '1;
    req_wrep  = '0;
    unique case (bus.req_size)
      2'b00: begin
        req_strb = NB'(1) << req_off;
        req_wrep = {NB{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        if (bus.req_addr[0]) req_fault = F_MIS;
        req_strb = NB'(2'b11) << req_off;
        req_wrep = {(NB/2){bus.req_wdata[15:0]}};
      end
      2'b10: begin
        if (|bus.req_addr[1:0]) req_fault = F_MIS;
        req_strb = NB'(4'hF) << req_off;
        req_wrep = {(NB/4){bus.req_wdata[31:0]}};
      end
      default: begin
        if (!HAS_DW)                 req_fault = F_SIZE;
        else if (|bus.req_addr[2:0]) req_fault = F_MIS;
        req_strb = '1;
        req_wrep = bus.req_wdata;
      end
    endcase
    // Loads read the whole word; the lane is picked out on return.
    if (!bus.req_we) begin
      req_strb = '1;
      req_wrep = '0;
    end
  end

  // Read-data lane extraction and sign/zero extension.
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ext;

  assign lane = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = lane;
    unique case (size_q)
      2'b00:   ext = uns_q ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
      2'b01:   ext = uns_q ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
      2'b10:   ext = uns_q ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
      default: ext = lane;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  // NOTE: the datapath registers are reset as well, because every bus and
  // response output must read 0 straight out of reset.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= F_OK;
      halt_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            off_q   <= req_off;
            addr_q  <= bus.req_addr & ~AW'(NB - 1);
            we_q    <= bus.req_we;
            wstrb_q <= req_strb;
            wdata_q <= req_wrep;
            cnt     <= '0;
            if (req_fault != F_OK) begin
              // Faulted requests never reach the bus.
              fault_q <= req_fault;
              rdata_q <= '0;
              halt_q  <= 1'b1;
              state   <= S_RESP;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (bus.mem_rdy) begin
            fault_q <= F_OK;
            rdata_q <= we_q ? '0 : ext;
            state   <= S_RESP;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            // cnt counts completed wait cycles, so mem_req is held for
            // exactly TIMEOUT cycles before giving up.
            fault_q <= F_TO;
            rdata_q <= '0;
            halt_q  <= 1'b1;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
  assign bus.mem_req    = (state == S_ACCESS);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_we     = (state == S_ACCESS) & we_q;
  assign bus.mem_wstrb  = wstrb_q;
  assign bus.mem_wdata  = wdata_q;
  assign halt           = halt_q;
endmodule
